// File: rtl/sequence_player_pkg.sv
// Shared game package: FSM state encodings, default playback timing and the
// sequence RAM geometry used by the player, the recorder and the RAM itself.
package sequence_player_pkg;

  // Sequence RAM geometry (16 entries of 4-bit colour codes)
  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;

  // Default playback timing in clock cycles
  localparam int DEFAULT_ON_CYCLES  = 1000;
  localparam int DEFAULT_OFF_CYCLES = 500;

  // Player FSM state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_SHOW  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

endpackage

// File: rtl/sequence_player_timer.sv
// Loadable down-counter shared by the SHOW and GAP phases of the player.
// Loading value v gives v+1 cycles until (and including) the expired cycle.
module player_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expired
);

  logic [W-1:0] count;

  // Reload on request, otherwise count down and park at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/sequence_player.sv
// Playback stage: walks the sequence RAM from address 0 to the captured last
// address, lighting each entry for ON_CYCLES followed by OFF_CYCLES blank.
//
// Handshake with the control unit: start is a request that is accepted only
// on an edge where the player is in IDLE (busy=0, done=0); once accepted,
// busy stays high for the whole playback and done pulses for exactly one
// cycle afterwards with busy low. start is ignored at all other times.
module sequence_player
  import sequence_player_pkg::*;
#(
  parameter int ON_CYCLES  = DEFAULT_ON_CYCLES,
  parameter int OFF_CYCLES = DEFAULT_OFF_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] leds,
  output logic              busy,
  output logic              done,
  output logic [2:0]        fsm_state
);

  localparam int MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES + 1) : 1;
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);

  logic [2:0]        state;
  logic [2:0]        next_state;
  logic [ADDR_W-1:0] last_reg;
  logic              timer_load;
  logic [TW-1:0]     timer_value;
  logic              timer_expired;

  player_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .expired    (timer_expired)
  );

  // Timer reloads on entry to SHOW (from LOAD) and on entry to GAP (SHOW end)
  always_comb begin
    timer_load  = 1'b0;
    timer_value = OFF_LOAD;
    if (state == ST_LOAD) begin
      timer_load  = 1'b1;
      timer_value = ON_LOAD;
    end else if (state == ST_SHOW && timer_expired) begin
      timer_load  = 1'b1;
      timer_value = OFF_LOAD;
    end
  end

  // Next-state logic for the playback FSM
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start) next_state = ST_FETCH;
      ST_FETCH: next_state = ST_LOAD;
      ST_LOAD:  next_state = ST_SHOW;
      ST_SHOW:  if (timer_expired) next_state = ST_GAP;
      ST_GAP: begin
        if (timer_expired) begin
          next_state = (ram_addr == last_reg) ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Address, last-index capture and LED register
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr <= '0;
      last_reg <= '0;
      leds     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            last_reg <= last_addr;
            ram_addr <= '0;
          end
        end
        // RAM output is valid here, one cycle after FETCH presented the address
        ST_LOAD: leds <= ram_q;
        ST_SHOW: if (timer_expired) leds <= '0;
        // Increment only when more entries remain, so the address never wraps
        ST_GAP: begin
          if (timer_expired && ram_addr != last_reg) begin
            ram_addr <= ram_addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == ST_FETCH) || (state == ST_LOAD) ||
                     (state == ST_SHOW)  || (state == ST_GAP);
  assign done      = (state == ST_DONE);
  assign fsm_state = state;

endmodule

// File: tb/tb_sequence_player.sv
// Testbench for sequence_player with ON_CYCLES=3, OFF_CYCLES=2 (7-cycle entry).
// Drivers push the expected per-cycle {busy,done,leds,ram_addr} trace into a
// queue; an independent monitor pops and compares one entry per clock.
module tb_sequence_player;
  import sequence_player_pkg::*;

  localparam int ON  = 3;
  localparam int OFF = 2;

  typedef logic [9:0] item_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] last_addr;
  logic [3:0] ram_addr;
  logic [3:0] ram_q;
  logic [3:0] leds;
  logic       busy;
  logic       done;
  logic [2:0] fsm_state;

  logic [3:0] mem [16];

  item_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_item   = 0;

  // Clock
  always #5 clk = ~clk;

  sequence_player #(
    .ON_CYCLES  (ON),
    .OFF_CYCLES (OFF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .last_addr (last_addr),
    .ram_addr  (ram_addr),
    .ram_q     (ram_q),
    .leds      (leds),
    .busy      (busy),
    .done      (done),
    .fsm_state (fsm_state)
  );

  // 16x4 synchronous sequence RAM, read-only from the player's point of view
  always @(posedge clk) ram_q <= mem[ram_addr];

  function automatic item_t mk(input logic b, input logic d,
                               input logic [3:0] l, input logic [3:0] a);
    return {b, d, l, a};
  endfunction

  // Scoreboard monitor: one comparison per cycle while expectations remain
  always @(negedge clk) begin
    item_t e;
    item_t g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {busy, done, leds, ram_addr};
      n_checks++;
      if (g === e) begin
        n_pass++;
      end else begin
        $display("FAIL trace[%0d] busy,done,leds,addr got %b,%b,%h,%h want %b,%b,%h,%h",
                 n_item, g[9], g[8], g[7:4], g[3:0], e[9], e[8], e[7:4], e[3:0]);
      end
      n_item++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_idle(input int n, input logic [3:0] a);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(1'b0, 1'b0, 4'h0, a));
  endtask

  // Expected playback trace of entries 0..last, then DONE and n_idle IDLE
  // cycles, truncated to the first 'limit' cycles.
  task automatic push_play(input int last, input int n_idle, input int limit);
    int pushed;
    item_t it;
    pushed = 0;
    for (int i = 0; i <= last; i++) begin
      for (int c = 0; c < 2 + ON + OFF; c++) begin
        if (c < 2)           it = mk(1'b1, 1'b0, 4'h0, 4'(i));
        else if (c < 2 + ON) it = mk(1'b1, 1'b0, mem[i], 4'(i));
        else                 it = mk(1'b1, 1'b0, 4'h0, 4'(i));
        if (pushed < limit) begin exp_q.push_back(it); pushed++; end
      end
    end
    if (pushed < limit) begin
      exp_q.push_back(mk(1'b0, 1'b1, 4'h0, 4'(last)));
      pushed++;
    end
    for (int j = 0; j < n_idle; j++) begin
      if (pushed < limit) begin
        exp_q.push_back(mk(1'b0, 1'b0, 4'h0, 4'(last)));
        pushed++;
      end
    end
  endtask

  // Wait for the monitor to consume every expectation, bounded
  task automatic drain(input int budget);
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < budget) begin
      tick(1);
      b++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout remaining %0d want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Pulse start for one cycle; returns just after the accepting edge
  task automatic start_pulse(input logic [3:0] la);
    last_addr = la;
    start     = 1'b1;
    tick(1);
    start     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

  // Directed stimulus
  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    last_addr = 4'h0;
    for (int i = 0; i < 16; i++) mem[i] = 4'h0;
    tick(2);

    // Reset state held with no start
    reset = 1'b0;
    push_idle(20, 4'h0);
    drain(40);

    // Single entry, RAM[0]=0001
    mem[0] = 4'b0001;
    start_pulse(4'd0);
    push_play(0, 2, 1000);
    drain(40);

    // Full 16-entry playback, RAM[i]=i
    for (int i = 0; i < 16; i++) mem[i] = 4'(i);
    start_pulse(4'd15);
    push_play(15, 2, 1000);
    drain(200);

    // Repeated start pulses and last_addr change during playback of 6 entries
    for (int i = 0; i < 16; i++) mem[i] = 4'(15 - i);
    start_pulse(4'd5);
    push_play(5, 2, 1000);
    for (int r = 0; r < 4; r++) begin
      tick(5);
      last_addr = 4'd2;
      start     = 1'b1;
      tick(1);
      start     = 1'b0;
    end
    drain(100);

    // Reset during the first SHOW cycle of entry 3
    start_pulse(4'd5);
    push_play(5, 0, 24);
    tick(23);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    push_idle(5, 4'h0);
    drain(40);
    start_pulse(4'd0);
    push_play(0, 2, 1000);
    drain(40);

    // start held high: DONE ignores it, IDLE after DONE restarts
    last_addr = 4'd1;
    start     = 1'b1;
    tick(1);
    push_play(1, 1, 1000);
    push_play(1, 2, 1000);
    tick(20);
    start = 1'b0;
    drain(100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sequence_player.md
# sequence_player

Playback stage for the memory-challenge game. It reads the stored colour sequence from the 16x4 synchronous sequence RAM, address 0 up to a requested last address, and shows each 4-bit entry on the LEDs for a fixed on-time followed by a blank gap. When the whole sequence has been shown it returns a one-cycle done pulse to the game's control unit. It drives the RAM address bus and consumes the RAM data output, which is valid one cycle after the address is registered by the RAM.

## Interface
Parameters:
- ON_CYCLES, 1000, clock cycles each entry stays lit (minimum 1)
- OFF_CYCLES, 500, clock cycles of blank gap after each entry (minimum 1)

Ports:
- clk  in  1  system clock, all state updates on its rising edge
- reset  in  1  synchronous reset, active-high; one clock, synchronous, active-high reset (fixed)
- start  in  1  request playback; sampled only in IDLE
- last_addr  in  4  index of the last entry to play; captured when start is accepted
- ram_addr  out  4  registered address to the sequence RAM
- ram_q  in  4  data from the sequence RAM
- leds  out  4  registered LED pattern; 0000 when blank
- busy  out  1  high while playback is in progress
- done  out  1  one-cycle pulse when playback completes

## Operation
- States:
  - IDLE
  - FETCH: 1 cycle. ram_addr is stable, and the RAM registers it at the end of this cycle.
  - LOAD: 1 cycle. ram_q is valid; leds <= ram_q at the end of this cycle.
  - SHOW: exactly ON_CYCLES cycles.
  - GAP: leds = 0000 for exactly OFF_CYCLES cycles.
  - DONE: 1 cycle.
- IDLE with start=1: capture last_addr into last_reg, set ram_addr <= 0, go to FETCH.
- IDLE with start=0: stay in IDLE.
- FETCH -> LOAD -> SHOW.
- SHOW -> GAP when the timer expires; leds <= 0000 on that edge.
- GAP end, ram_addr == last_reg: go to DONE.
- GAP end, ram_addr != last_reg: ram_addr <= ram_addr + 1, go to FETCH.
- DONE -> IDLE.
- busy = 1 in FETCH, LOAD, SHOW and GAP; 0 in IDLE and DONE.
- done = 1 only in DONE.
- start is ignored in every state except IDLE, including DONE.
- last_addr changes after start has been accepted have no effect.
- last_addr = 15 plays 16 entries. ram_addr never wraps: the last_reg compare always fires at or before 15.
- The timer is a down-counter sized to hold max(ON_CYCLES, OFF_CYCLES). It reloads on entry to SHOW and on entry to GAP.
- The block never writes the RAM; the RAM write-enable is owned by the recorder stage.

## Timing
- Reset values: state IDLE, ram_addr 0000, leds 0000, busy 0, done 0, last_reg 0000, timer 0.
- Reset asserted in any state returns everything to the reset values on the next edge. There is no partial completion and no done pulse.
- With start accepted at edge k:
  - busy = 1 from cycle k+1 (FETCH, ram_addr = 0).
  - leds shows entry 0 from cycle k+3 for ON_CYCLES cycles.
- Per-entry period: 2 + ON_CYCLES + OFF_CYCLES cycles.
- For N = last_reg + 1 entries, done is high exactly N·(2 + ON_CYCLES + OFF_CYCLES) cycles after busy rises, for one cycle. busy is low in that cycle.
- The earliest restart is a start sampled in the IDLE cycle that follows DONE.

## Structure
- Shared game package holds:
  - the state encoding localparams (IDLE, FETCH, LOAD, SHOW, GAP, DONE);
  - the default ON_CYCLES and OFF_CYCLES values;
  - the RAM address and data widths (4, 4), shared with the RAM and the recorder.
- One sub-module: player_timer.
  - A loadable down-counter with load, load_value and expired ports, reused for both SHOW and GAP.
- The FSM and address register stay in sequence_player.

## Test plan
Benches use ON_CYCLES=3 and OFF_CYCLES=2, giving a 7-cycle per-entry period.
- Reset, no start -> leds 0000, ram_addr 0000, busy 0, done 0, held for 20 cycles.
- RAM[0]=0001, last_addr=0, one start pulse:
  - busy rises the next cycle;
  - leds 0001 for exactly 3 cycles starting 2 cycles after busy rises, then 0000;
  - done pulses once, 7 cycles after busy rises.
- RAM[i]=i, last_addr=15:
  - leds sequence 0,1,…,15, each for 3 cycles;
  - ram_addr 0..15 with no wrap;
  - done 112 cycles after busy rises.
- Repeated start pulses and last_addr changed to 2 during playback of last_addr=5 -> exactly 6 entries played, single done pulse.
- reset asserted during SHOW of entry 3 -> next cycle leds 0000, busy 0, ram_addr 0000, no done; a later start plays from entry 0.
- start held high continuously with last_addr=1 -> playback runs, done pulses, start is ignored in DONE, and a new playback begins from IDLE (busy rises 2 cycles after done).
